// File: rtl/prio_sel_pipe_pkg.sv
// Shared types and sizing helpers for the priority select pipe.
package prio_sel_pkg;

  typedef enum logic {
    SEL_FIXED = 1'b0,
    SEL_RR    = 1'b1
  } sel_mode_e;

  localparam int STATS_W = 16;

  // Channel index width: max(1, clog2(n)).
  function automatic int chan_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_sel_pipe_if.sv
// Request/select/output bundle between N producers and one consumer.
interface prio_sel_pipe_if #(
  parameter int N = 4,
  parameter int W = 8
);
  import prio_sel_pkg::*;

  localparam int CW = chan_idx_w(N);

  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_req;
  logic [N-1:0]   in_ack;
  logic [W-1:0]   dflt_data;
  logic [W-1:0]   comb_data;
  logic [CW-1:0]  comb_chan;
  logic [W-1:0]   out_data;
  logic [CW-1:0]  out_chan;
  logic           out_valid;
  logic           out_ready;

  modport master (
    output in_data, in_req, dflt_data, out_ready,
    input  in_ack, comb_data, comb_chan, out_data, out_chan, out_valid
  );

  modport slave (
    input  in_data, in_req, dflt_data, out_ready,
    output in_ack, comb_data, comb_chan, out_data, out_chan, out_valid
  );

endinterface

// File: rtl/prio_sel_pipe_arb.sv
// Combinational winner select: fixed (highest index) or round-robin after rr_ptr.
module prio_sel_arb
  import prio_sel_pkg::*;
#(
  parameter int N       = 4,
  parameter int RR_MODE = 0
) (
  input  logic [N-1:0]               req,
  input  logic [chan_idx_w(N)-1:0]   rr_ptr,
  output logic [chan_idx_w(N)-1:0]   win,
  output logic                       any
);
  localparam int        CW   = chan_idx_w(N);
  localparam sel_mode_e MODE = (RR_MODE != 0) ? SEL_RR : SEL_FIXED;

  always_comb begin
    win = '0;
    any = |req;
    if (MODE == SEL_FIXED) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) win = CW'(i);
      end
    end else begin
      // Walk search offsets far-to-near so the nearest requester after rr_ptr is assigned last.
      for (int k = N; k >= 1; k--) begin
        for (int i = 0; i < N; i++) begin
          if (req[i] && (((int'(rr_ptr) + k) % N) == i)) win = CW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/prio_sel_pipe.sv
// N-way priority/round-robin select into a one-deep valid/ready output stage, 1-cycle latency.
// Optional PRIO_SEL_PIPE_STATS_EN adds a saturating transfer counter and a sticky stall flag.
module prio_sel_pipe
  import prio_sel_pkg::*;
#(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int RR_MODE = 0
) (
  input  logic           clock,
  input  logic           reset,
  prio_sel_pipe_if.slave bus
`ifdef PRIO_SEL_PIPE_STATS_EN
  ,
  output logic [STATS_W-1:0] xfer_cnt,
  output logic               stall_seen
`endif
);
  localparam int CW = chan_idx_w(N);

  logic [CW-1:0] rr_ptr_q, rr_ptr_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [CW-1:0] out_chan_q, out_chan_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] win;
  logic          any;
  logic          load;
  logic [W-1:0]  sel_data;

  prio_sel_arb #(.N(N), .RR_MODE(RR_MODE)) u_arb (
    .req    (bus.in_req),
    .rr_ptr (rr_ptr_q),
    .win    (win),
    .any    (any)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (win == CW'(i)) sel_data = bus.in_data[i*W +: W];
    end
  end

  // Loading while draining is allowed, so the stage only blocks on valid && !ready.
  assign load          = any && (!out_valid_q || bus.out_ready);
  assign bus.in_ack    = load ? (N'(1) << win) : '0;
  assign bus.comb_data = any ? sel_data : bus.dflt_data;
  assign bus.comb_chan = any ? win : '0;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_valid = out_valid_q;

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    if (load) begin
      rr_ptr_d    = win;
      out_data_d  = sel_data;
      out_chan_d  = win;
      out_valid_d = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q    <= CW'(N - 1);
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef PRIO_SEL_PIPE_STATS_EN
  logic [STATS_W-1:0] xfer_cnt_q, xfer_cnt_d;
  logic               stall_seen_q, stall_seen_d;

  always_comb begin
    xfer_cnt_d   = xfer_cnt_q;
    stall_seen_d = stall_seen_q | (out_valid_q && !bus.out_ready);
    if (out_valid_q && bus.out_ready && (xfer_cnt_q != '1)) xfer_cnt_d = xfer_cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      xfer_cnt_q   <= '0;
      stall_seen_q <= 1'b0;
    end else begin
      xfer_cnt_q   <= xfer_cnt_d;
      stall_seen_q <= stall_seen_d;
    end
  end

  assign xfer_cnt   = xfer_cnt_q;
  assign stall_seen = stall_seen_q;
`endif

endmodule

// File: tb/tb_prio_sel_pipe.sv
// Bench for prio_sel_pipe: fixed N=4, round-robin N=4 and round-robin N=5 against a behavioural model.
module tb_prio_sel_pipe;
  import prio_sel_pkg::*;

  localparam int ND = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic chk_en = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic [4:0]  req  [ND];
  logic [39:0] data [ND];
  logic        rdy  [ND];
  logic [7:0]  dflt;

  logic [4:0] o_ack   [ND];
  logic [7:0] o_cdat  [ND];
  logic [2:0] o_cchan [ND];
  logic [7:0] o_dat   [ND];
  logic [2:0] o_chan  [ND];
  logic       o_vld   [ND];

  int         m_ptr   [ND];
  logic [7:0] m_data  [ND];
  int         m_chan  [ND];
  bit         m_valid [ND];

  always #5 clock = ~clock;

  prio_sel_pipe_if #(.N(4), .W(8)) b_a ();
  prio_sel_pipe_if #(.N(4), .W(8)) b_b ();
  prio_sel_pipe_if #(.N(5), .W(8)) b_c ();

  assign b_a.in_req = req[0][3:0];  assign b_a.in_data = data[0][31:0];
  assign b_b.in_req = req[1][3:0];  assign b_b.in_data = data[1][31:0];
  assign b_c.in_req = req[2];       assign b_c.in_data = data[2];
  assign b_a.out_ready = rdy[0];    assign b_a.dflt_data = dflt;
  assign b_b.out_ready = rdy[1];    assign b_b.dflt_data = dflt;
  assign b_c.out_ready = rdy[2];    assign b_c.dflt_data = dflt;

  assign o_ack[0] = {1'b0, b_a.in_ack};  assign o_cdat[0] = b_a.comb_data;
  assign o_ack[1] = {1'b0, b_b.in_ack};  assign o_cdat[1] = b_b.comb_data;
  assign o_ack[2] = b_c.in_ack;          assign o_cdat[2] = b_c.comb_data;
  assign o_cchan[0] = {1'b0, b_a.comb_chan};  assign o_chan[0] = {1'b0, b_a.out_chan};
  assign o_cchan[1] = {1'b0, b_b.comb_chan};  assign o_chan[1] = {1'b0, b_b.out_chan};
  assign o_cchan[2] = b_c.comb_chan;          assign o_chan[2] = b_c.out_chan;
  assign o_dat[0] = b_a.out_data;  assign o_vld[0] = b_a.out_valid;
  assign o_dat[1] = b_b.out_data;  assign o_vld[1] = b_b.out_valid;
  assign o_dat[2] = b_c.out_data;  assign o_vld[2] = b_c.out_valid;

`ifdef PRIO_SEL_PIPE_STATS_EN
  logic [15:0] xc [ND];
  logic        ss [ND];
`endif

  prio_sel_pipe #(.N(4), .W(8), .RR_MODE(0)) u_fix4 (
    .clock(clock), .reset(reset), .bus(b_a)
`ifdef PRIO_SEL_PIPE_STATS_EN
    , .xfer_cnt(xc[0]), .stall_seen(ss[0])
`endif
  );
  prio_sel_pipe #(.N(4), .W(8), .RR_MODE(1)) u_rr4 (
    .clock(clock), .reset(reset), .bus(b_b)
`ifdef PRIO_SEL_PIPE_STATS_EN
    , .xfer_cnt(xc[1]), .stall_seen(ss[1])
`endif
  );
  prio_sel_pipe #(.N(5), .W(8), .RR_MODE(1)) u_rr5 (
    .clock(clock), .reset(reset), .bus(b_c)
`ifdef PRIO_SEL_PIPE_STATS_EN
    , .xfer_cnt(xc[2]), .stall_seen(ss[2])
`endif
  );

  function automatic int nch(input int d);
    return (d == 2) ? 5 : 4;
  endfunction

  // Winner from the rules: highest requester, or first requester scanning upward after the pointer.
  function automatic int mwin(input int d);
    int n;
    n = nch(d);
    if (req[d] == 0) return -1;
    if (d == 0) begin
      for (int i = n - 1; i >= 0; i--) if (req[d][i]) return i;
    end else begin
      for (int k = 1; k <= n; k++) if (req[d][(m_ptr[d] + k) % n]) return (m_ptr[d] + k) % n;
    end
    return -1;
  endfunction

  function automatic logic [7:0] chdat(input int d, input int w);
    logic [39:0] s;
    s = data[d] >> (w * 8);
    return s[7:0];
  endfunction

  task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d got=%0h want=%0h t=%0t", nm, d, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      for (int d = 0; d < ND; d++) begin
        int  w;
        bit  ld;
        w  = mwin(d);
        ld = (w >= 0) && (!m_valid[d] || rdy[d]);
        chk("comb_data", d, o_cdat[d], (w < 0) ? dflt : chdat(d, w));
        chk("comb_chan", d, o_cchan[d], (w < 0) ? 0 : w);
        chk("in_ack", d, o_ack[d], ld ? (64'd1 << w) : 64'd0);
        chk("out_valid", d, o_vld[d], m_valid[d]);
        chk("out_data", d, o_dat[d], m_data[d]);
        chk("out_chan", d, o_chan[d], m_chan[d]);
      end
    end
  end

  always @(posedge clock) begin
    for (int d = 0; d < ND; d++) begin
      int w;
      w = mwin(d);
      if (reset) begin
        m_valid[d] = 1'b0;
        m_data[d]  = 8'h00;
        m_chan[d]  = 0;
        m_ptr[d]   = nch(d) - 1;
      end else if ((w >= 0) && (!m_valid[d] || rdy[d])) begin
        m_valid[d] = 1'b1;
        m_data[d]  = chdat(d, w);
        m_chan[d]  = w;
        m_ptr[d]   = w;
      end else if (m_valid[d] && rdy[d]) begin
        m_valid[d] = 1'b0;
      end
    end
  end

  initial begin
    dflt = 8'h00;
    for (int d = 0; d < ND; d++) begin
      req[d] = '0; data[d] = '0; rdy[d] = 1'b1;
    end
    reset = 1'b1;
    repeat (2) cyc();
    for (int d = 0; d < ND; d++) begin
      chk("rst_valid", d, o_vld[d], 0);
      chk("rst_data", d, o_dat[d], 0);
      chk("rst_chan", d, o_chan[d], 0);
    end
    reset  = 1'b0;
    chk_en = 1'b1;

    // Fixed priority picks channel 2 of {1,2}, then drains to idle.
    req[0]  = 5'b00110;
    data[0] = 40'h00D0C0B0A0;
    #1;
    chk("t1_comb_data", 0, o_cdat[0], 8'hC0);
    chk("t1_comb_chan", 0, o_cchan[0], 2);
    chk("t1_ack", 0, o_ack[0], 5'b00100);
    cyc();
    req[0] = '0;
    dflt   = 8'h5A;
    #1;
    chk("t1_out_data", 0, o_dat[0], 8'hC0);
    chk("t1_out_valid", 0, o_vld[0], 1);
    chk("t2_comb_data", 0, o_cdat[0], 8'h5A);
    chk("t2_ack", 0, o_ack[0], 0);
    cyc();
    chk("t2_drained", 0, o_vld[0], 0);

    // Round-robin rotation with all requesting; N=5 wraps from 4 back to 0.
    req[1] = 5'h0F;
    req[2] = 5'h1F;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("t3_rr4_chan", 1, o_chan[1], i % 4);
      chk("t3_rr5_chan", 2, o_chan[2], i % 5);
    end
    req[1] = '0;
    req[2] = '0;
    cyc();

    // Stall holds the stage; release grants channel 3 in the same cycle.
    rdy[0]  = 1'b0;
    req[0]  = 5'b00001;
    data[0] = 40'h0011223344;
    cyc();
    req[0] = 5'b01000;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_stall_ack", 0, o_ack[0], 0);
      chk("t4_stall_data", 0, o_dat[0], 8'h44);
      chk("t4_stall_chan", 0, o_chan[0], 0);
      chk("t4_stall_valid", 0, o_vld[0], 1);
      cyc();
    end
    rdy[0] = 1'b1;
    #1;
    chk("t4_release_ack", 0, o_ack[0], 5'b01000);
    cyc();
    chk("t4_release_chan", 0, o_chan[0], 3);
    chk("t4_release_data", 0, o_dat[0], 8'h11);
    req[0] = '0;
    cyc();

    // Reset while stalled discards the word and restores channel 0 first priority.
    rdy[1]  = 1'b0;
    data[1] = 40'h0099887766;
    req[1]  = 5'b00100;
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("t5_rst_valid", 1, o_vld[1], 0);
    chk("t5_rst_data", 1, o_dat[1], 0);
    req[1] = 5'h0F;
    rdy[1] = 1'b1;
    cyc();
    chk("t5_first_grant", 1, o_chan[1], 0);
    req[1] = '0;
    cyc();

    repeat (3000) begin
      cyc();
      reset = ($urandom_range(0, 199) == 0);
      dflt  = 8'($urandom);
      for (int d = 0; d < ND; d++) begin
        req[d]  = 5'($urandom) & ((d == 2) ? 5'h1F : 5'h0F);
        data[d] = {8'($urandom), 32'($urandom)};
        rdy[d]  = ($urandom_range(0, 3) != 0);
      end
    end
    cyc();
    reset = 1'b0;
    for (int d = 0; d < ND; d++) begin
      req[d] = '0; rdy[d] = 1'b1;
    end
    cyc();

`ifdef PRIO_SEL_PIPE_STATS_EN
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("st_cnt_rst", 0, xc[0], 0);
    chk("st_stall_rst", 0, ss[0], 0);
    req[0] = 5'b00001;
    repeat (70000) cyc();
    chk("st_cnt_sat", 0, xc[0], 16'hFFFF);
    chk("st_no_stall", 0, ss[0], 0);
    rdy[0] = 1'b0;
    cyc();
    chk("st_stall_set", 0, ss[0], 1);
    rdy[0] = 1'b1;
    repeat (3) cyc();
    chk("st_stall_sticky", 0, ss[0], 1);
    req[0] = '0;
    reset  = 1'b1;
    cyc();
    reset = 1'b0;
    chk("st_stall_clr", 0, ss[0], 0);
    chk("st_cnt_clr", 0, xc[0], 0);
    cyc();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
